// File: rtl/nand_seq_pkg.sv
// nand_seq_pkg: op encodings, FSM states and per-op NAND step counts
package nand_seq_pkg;
  localparam logic [1:0] OP_NAND = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  function automatic logic [2:0] op_steps(input logic [1:0] op);
    return op == OP_NAND ? 3'd1 : op == OP_AND ? 3'd2 : op == OP_OR ? 3'd3 : 3'd4;
  endfunction
endpackage

// File: rtl/nand_seq_arbiter_nand_array.sv
// nand_array: WIDTH gate-level NAND primitives, the only NAND logic in the sequencer
module nand_array #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] fout
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_nand
    nand u_nand (fout[i], x[i], y[i]);
  end
endmodule

// File: rtl/nand_seq_arbiter.sv
// nand_seq_arbiter: round-robins one shared NAND array between NREQ requesters,
// evaluating NAND/AND/OR/XOR as serial NAND steps
module nand_seq_arbiter
  import nand_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ = 2,
  localparam int IDW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_a,
  input  logic [WIDTH*NREQ-1:0]   req_b,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_data,
  input  logic                    rsp_ready
);
  state_t state, state_n;
  logic [IDW-1:0] last_grant, grant, idx, id;
  logic found, last_step, to_r1;
  logic [1:0] op, step;
  logic [WIDTH-1:0] a, b, r0, r1, x, y, fout;
  logic [WIDTH-1:0] a_in [NREQ];
  logic [WIDTH-1:0] b_in [NREQ];
  logic [1:0] op_in [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_in[i] = req_a[WIDTH*i +: WIDTH];
    assign b_in[i] = req_b[WIDTH*i +: WIDTH];
    assign op_in[i] = req_op[2*i +: 2];
  end

  // first valid requester searching upward from the one after last_grant
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_grant) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign req_ready = (state == IDLE && found) ? NREQ'(1) << grant : '0;

  // operand routing per step; r1 is only written as the second step of OR and XOR
  assign x = op == OP_OR  ? (step == 2'd0 ? a : step == 2'd1 ? b : r0)
           : op == OP_XOR ? (step <= 2'd1 ? a : step == 2'd2 ? b : r0)
           :                (step == 2'd0 ? a : r0);
  assign y = op == OP_OR  ? (step == 2'd0 ? a : step == 2'd1 ? b : r1)
           : op == OP_XOR ? (step == 2'd0 ? b : step == 2'd3 ? r1 : r0)
           :                (step == 2'd0 ? b : r0);
  assign to_r1 = step == 2'd1 && (op == OP_OR || op == OP_XOR);
  assign last_step = {1'b0, step} == op_steps(op) - 3'd1;

  nand_array #(.WIDTH(WIDTH)) u_array (
    .x(x),
    .y(y),
    .fout(fout)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state == IDLE ? (found ? EXEC : IDLE)
            : state == EXEC ? (last_step ? RESP : EXEC)
            : state == RESP ? (rsp_ready ? IDLE : RESP)
            : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IDW'(NREQ - 1);
      id <= '0;
      a <= '0;
      b <= '0;
      op <= OP_NAND;
      step <= '0;
      r0 <= '0;
      r1 <= '0;
    end else if (state == IDLE && found) begin
      last_grant <= grant;
      id <= grant;
      a <= a_in[grant];
      b <= b_in[grant];
      op <= op_in[grant];
      step <= '0;
    end else if (state == EXEC) begin
      step <= step + 2'd1;
      if (to_r1) r1 <= fout;
      else r0 <= fout;
    end
  end

  assign rsp_valid = state == RESP;
  assign rsp_id = id;
  assign rsp_data = r0;
endmodule

// File: tb/tb_nand_seq_arbiter.sv
// tb_nand_seq_arbiter: directed and randomized checks of the shared-NAND sequencer
// against a bitwise-operator reference model
module tb_nand_seq_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  logic [3:0] req_op;
  logic [15:0] req_a, req_b;
  logic rsp_valid;
  logic rsp_id;
  logic [7:0] rsp_data;
  logic rsp_ready = 1'b1;
  logic [1:0] op_r [2] = '{2'b00, 2'b00};
  logic [7:0] a_r [2] = '{8'h00, 8'h00};
  logic [7:0] b_r [2] = '{8'h00, 8'h00};
  int checks = 0;
  int errors = 0;

  assign req_op = {op_r[1], op_r[0]};
  assign req_a = {a_r[1], a_r[0]};
  assign req_b = {b_r[1], b_r[0]};

  always #5 clk = ~clk;

  nand_seq_arbiter #(.WIDTH(8), .NREQ(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_a(req_a),
    .req_b(req_b),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .rsp_ready(rsp_ready)
  );

  function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00: return ~(a & b);
      2'b01: return a & b;
      2'b10: return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // issues one op on requester id and returns once rsp_valid is seen (lat = -1 on timeout)
  task automatic run_op(input logic id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input bit mut, output int lat, output logic [7:0] data, output logic rid);
    int n;
    op_r[id] = op;
    a_r[id] = a;
    b_r[id] = b;
    req_valid[id] = 1'b1;
    #1;
    lat = -1;
    data = 'x;
    rid = 'x;
    n = 0;
    while (!req_ready[id] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!req_ready[id]) begin
      req_valid[id] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    if (mut) a_r[id] = ~a;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (rsp_valid) begin
      lat = n;
      data = rsp_data;
      rid = rsp_id;
      if (rsp_ready) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset rsp_valid: got %b want 0", rsp_valid); end
    checks++;
    if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset rsp_data: got %h want 00", rsp_data); end
    checks++;
    if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset rsp_id: got %b want 0", rsp_id); end
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL reset req_ready: got %b want 00", req_ready); end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 2'b11;
    #1;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL reset first priority: got %b want 01", req_ready); end
    checks++;
    req_valid = 2'b00;
    @(posedge clk);
    #1;
    req_valid = 2'b10;
    #1;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL dropped valid accepted: got %b want 10", req_ready); end
    checks++;
    req_valid = 2'b00;
  endtask

  task automatic test_single();
    logic [7:0] va [2] = '{8'hC5, 8'hF0};
    logic [7:0] vb [2] = '{8'h3A, 8'hCC};
    logic [7:0] want [8] = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h3F, 8'hC0, 8'hFC, 8'h3C};
    int lat;
    logic [7:0] d;
    logic rid;
    rsp_ready = 1'b1;
    for (int v = 0; v < 2; v++) begin
      for (int o = 0; o < 4; o++) begin
        run_op(1'(o % 2), 2'(o), va[v], vb[v], 1'b0, lat, d, rid);
        if (d !== want[4*v+o]) begin
          errors++;
          $display("FAIL single op=%0d a=%h data: got %h want %h", o, va[v], d, want[4*v+o]);
        end
        checks++;
        if (lat != o + 1 || rid !== 1'(o % 2)) begin
          errors++;
          $display("FAIL single op=%0d latency/id: got %0d/%b want %0d/%b", o, lat, rid, o + 1, 1'(o % 2));
        end
        checks++;
      end
    end
  endtask

  task automatic test_round_robin();
    int n;
    logic e;
    do_reset();
    op_r[0] = 2'b11; a_r[0] = 8'hF0; b_r[0] = 8'hCC;
    op_r[1] = 2'b01; a_r[1] = 8'h5A; b_r[1] = 8'h3C;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      e = 1'(i % 2);
      n = 0;
      while (!rsp_valid && n < 10) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (rsp_valid !== 1'b1 || rsp_id !== e) begin
        errors++;
        $display("FAIL round robin %0d id: got valid=%b id=%b want id %b", i, rsp_valid, rsp_id, e);
      end
      checks++;
      if (rsp_data !== model(op_r[e], a_r[e], b_r[e])) begin
        errors++;
        $display("FAIL round robin %0d data: got %h want %h", i, rsp_data, model(op_r[e], a_r[e], b_r[e]));
      end
      checks++;
      @(posedge clk);
      #1;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_back_pressure();
    int lat;
    logic [7:0] d;
    logic rid;
    logic [7:0] want;
    do_reset();
    want = model(2'b01, 8'hF0, 8'hCC);
    rsp_ready = 1'b0;
    run_op(1'b0, 2'b01, 8'hF0, 8'hCC, 1'b0, lat, d, rid);
    op_r[1] = 2'b00; a_r[1] = 8'h96; b_r[1] = 8'h0F;
    req_valid[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, want} || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL stall cycle %0d: got v=%b id=%b d=%h rdy=%b want v=1 id=0 d=%h rdy=00",
                 i, rsp_valid, rsp_id, rsp_data, req_ready, want);
      end
      checks++;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin
      errors++;
      $display("FAIL stall release: got v=%b rdy=%b want v=0 rdy=10", rsp_valid, req_ready);
    end
    checks++;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL next accept: got rdy=%b want 00", req_ready); end
    checks++;
    @(posedge clk);
    #1;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, model(2'b00, 8'h96, 8'h0F)}) begin
      errors++;
      $display("FAIL post-stall nand: got v=%b id=%b d=%h want v=1 id=1 d=%h",
               rsp_valid, rsp_id, rsp_data, model(2'b00, 8'h96, 8'h0F));
    end
    checks++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_operand_change();
    int lat;
    logic [7:0] d;
    logic rid;
    rsp_ready = 1'b1;
    run_op(1'b1, 2'b11, 8'hA7, 8'h5C, 1'b1, lat, d, rid);
    if (d !== model(2'b11, 8'hA7, 8'h5C) || lat != 4) begin
      errors++;
      $display("FAIL operand change: got d=%h lat=%0d want d=%h lat=4", d, lat, model(2'b11, 8'hA7, 8'h5C));
    end
    checks++;
  endtask

  task automatic test_reset_mid_xor();
    int n;
    rsp_ready = 1'b1;
    op_r[0] = 2'b11; a_r[0] = 8'hF0; b_r[0] = 8'hCC;
    req_valid = 2'b01;
    #1;
    n = 0;
    while (!req_ready[0] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = 2'b00;
    #1;
    if ({rsp_valid, rsp_id, rsp_data, req_ready} !== {1'b0, 1'b0, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL reset mid xor: got v=%b id=%b d=%h rdy=%b want all zero", rsp_valid, rsp_id, rsp_data, req_ready);
    end
    checks++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL discarded op responded: got v=%b want 0", rsp_valid); end
      checks++;
    end
    op_r[1] = 2'b00;
    req_valid = 2'b11;
    #1;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL post-reset priority: got %b want 01", req_ready); end
    checks++;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL post-reset first grant: got v=%b id=%b want v=1 id=0", rsp_valid, rsp_id);
    end
    checks++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [1:0] mask;
    logic [1:0] ops [2];
    logic [7:0] av [2];
    logic [7:0] bv [2];
    logic [7:0] want;
    logic last, e;
    int n;
    do_reset();
    last = 1'b1;
    for (int it = 0; it < 40; it++) begin
      mask = 2'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++) begin
        ops[i] = 2'($urandom);
        av[i] = 8'($urandom);
        bv[i] = 8'($urandom);
        op_r[i] = ops[i];
        a_r[i] = av[i];
        b_r[i] = bv[i];
      end
      e = mask[~last] ? ~last : last;
      want = model(ops[e], av[e], bv[e]);
      rsp_ready = 1'($urandom);
      req_valid = mask;
      #1;
      if (req_ready !== (e ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL random %0d grant: got %b want %b (mask %b)", it, req_ready, e ? 2'b10 : 2'b01, mask);
      end
      checks++;
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      a_r[0] = 8'($urandom);
      b_r[1] = 8'($urandom);
      n = 0;
      while (!rsp_valid && n < 10) begin
        @(posedge clk);
        #1;
        n++;
      end
      rsp_ready = 1'b0;
      if (n != int'(ops[e]) + 1 || rsp_id !== e || rsp_data !== want) begin
        errors++;
        $display("FAIL random %0d response: got lat=%0d id=%b d=%h want lat=%0d id=%b d=%h",
                 it, n, rsp_id, rsp_data, int'(ops[e]) + 1, e, want);
      end
      checks++;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
        if ({rsp_valid, rsp_data} !== {1'b1, want}) begin
          errors++;
          $display("FAIL random %0d hold: got v=%b d=%h want v=1 d=%h", it, rsp_valid, rsp_data, want);
        end
        checks++;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL random %0d handshake: got v=%b want 0", it, rsp_valid); end
      checks++;
      last = e;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_operand_change();
    test_reset_mid_xor();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
